// File: rtl/consmax_pkg.sv
// Shared constants and loader state encoding for the consmax LUT loader.
package consmax_pkg;

  localparam int IDATA_BIT = 8;
  localparam int CDATA_BIT = 8;
  localparam int EXP_BIT   = 8;
  localparam int MAT_BIT   = 7;
  localparam int LUT_DATA  = EXP_BIT + MAT_BIT + 1;  // {sign, exp, mant}
  localparam int LUT_ADDR  = IDATA_BIT >> 1;         // per-table address width
  localparam int LUT_DEPTH = 2 ** LUT_ADDR;          // entries per table
  localparam int NUM_ENT   = 2 * LUT_DEPTH;          // the loader fills both tables
  localparam int CNT_W     = LUT_ADDR + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } loader_state_e;

  // Rotate a LUT word left by one bit.
  function automatic logic [LUT_DATA-1:0] rotl1(input logic [LUT_DATA-1:0] v);
    return {v[LUT_DATA-2:0], v[LUT_DATA-1]};
  endfunction

endpackage

// File: rtl/consmax_lut_csum.sv
// Rotate-left-1 / XOR accumulator over the LUT entries accepted during a load.
module consmax_lut_csum
  import consmax_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                clr_i,
  input  logic                en_i,
  input  logic [LUT_DATA-1:0] data_i,
  output logic [LUT_DATA-1:0] csum_o
);

  logic [LUT_DATA-1:0] csum_q;
  logic [LUT_DATA-1:0] csum_d;

  // Clear wins over accumulate; otherwise hold.
  always_comb begin
    csum_d = csum_q;
    if (clr_i) begin
      csum_d = '0;
    end else if (en_i) begin
      csum_d = rotl1(csum_q) ^ data_i;
    end
  end

  // Checksum register.
  always_ff @(posedge clk) begin
    if (rst) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign csum_o = csum_q;

endmodule

// File: rtl/consmax_lut_loader.sv
// Write-side driver for the consmax exponent LUT. Accepts a valid/ready stream
// of NUM_ENT entries, writes them to addresses 0..NUM_ENT-1 with one cycle of
// latency, latches the shift config on start and gates idata_valid until a
// complete table is resident.
// Optional build macro: CONSMAX_LUT_CSUM_EN adds a rotate-XOR checksum on lut_csum.
module consmax_lut_loader
  import consmax_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CDATA_BIT-1:0] cfg_shift_in,
  input  logic [LUT_DATA-1:0]  s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic [LUT_ADDR:0]    lut_waddr,
  output logic                 lut_wen,
  output logic [LUT_DATA-1:0]  lut_wdata,
  output logic [CDATA_BIT-1:0] cfg_consmax_shift,
  input  logic [IDATA_BIT-1:0] in_idata,
  input  logic                 in_idata_valid,
  output logic [IDATA_BIT-1:0] idata,
  output logic                 idata_valid,
  output logic                 busy,
  output logic                 done,
  output logic                 loaded,
  output logic [LUT_DATA-1:0]  lut_csum
);

  loader_state_e        state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 wen_q, wen_d;
  logic [CNT_W-1:0]     waddr_q, waddr_d;
  logic [LUT_DATA-1:0]  wdata_q, wdata_d;
  logic [CDATA_BIT-1:0] shift_q, shift_d;
  logic                 loaded_q, loaded_d;

  logic accept;
  logic start_acc;

  assign s_ready   = (state_q == LOAD);
  assign accept    = s_valid & s_ready;
  // A start outside IDLE is dropped so an in-flight load cannot be restarted.
  assign start_acc = start & (state_q == IDLE);

  // Next-state logic: sequence accepted entries into registered LUT writes.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wen_d    = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    shift_d  = shift_q;
    loaded_d = loaded_q;
    case (state_q)
      IDLE: begin
        if (start_acc) begin
          state_d  = LOAD;
          cnt_d    = '0;
          loaded_d = 1'b0;
          shift_d  = cfg_shift_in;
        end
      end
      LOAD: begin
        if (accept) begin
          wen_d   = 1'b1;
          waddr_d = cnt_q;
          wdata_d = s_data;
          cnt_d   = cnt_q + 1'b1;
          // Only the final entry completes the table; loaded rises with done.
          if (cnt_q == CNT_W'(NUM_ENT - 1)) begin
            state_d  = DONE;
            loaded_d = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      wen_q    <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      shift_q  <= '0;
      loaded_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wen_q    <= wen_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      shift_q  <= shift_d;
      loaded_q <= loaded_d;
    end
  end

  assign lut_wen           = wen_q;
  assign lut_waddr         = waddr_q;
  assign lut_wdata         = wdata_q;
  assign cfg_consmax_shift = shift_q;
  assign busy              = (state_q != IDLE);
  assign done              = (state_q == DONE);
  assign loaded            = loaded_q;

  // Upstream data is never stalled; its valid is simply masked while no
  // complete table is resident or a load is in progress.
  assign idata       = in_idata;
  assign idata_valid = in_idata_valid & loaded_q & ~busy;

`ifdef CONSMAX_LUT_CSUM_EN
  consmax_lut_csum u_csum (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (start_acc),
    .en_i   (accept),
    .data_i (s_data),
    .csum_o (lut_csum)
  );
`else
  assign lut_csum = '0;
`endif

endmodule
